// File: rtl/apb_mem_slave.sv
// APB word-addressed memory slave with a programmable number of wait states.
// Registered PREADY/PSLVERR/PRDATA; dbg_state_o exposes the FSM state.
module apb_mem_slave #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [1:0]  dbg_state_o
);

  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Handshake: a transfer starts with a setup cycle (PSEL=1, PENABLE=0) and
  // completes on the edge where PSEL=PENABLE=PREADY=1; dropping PSEL aborts.
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] prdata_q;
  logic        pready_q;
  logic        pslverr_q;
  logic [31:0] mem_q [DEPTH];

  logic          setup;
  logic [31:0]   addr_n;
  logic          write_n;
  logic [AW-1:0] idx_n;
  logic          err_n;
  logic [31:0]   rdata_n;
  logic          mem_we;

  assign setup = PSEL && !PENABLE;

  // With zero wait states the response is built from the setup-phase inputs
  // in the same edge that latches them.
  assign addr_n  = (state_q == S_IDLE) ? PADDR : addr_q;
  assign write_n = (state_q == S_IDLE) ? PWRITE : write_q;
  assign idx_n   = addr_n[AW+1:2];
  assign err_n   = (addr_n[1:0] != 2'b00) || (addr_n >= LIMIT);
  assign rdata_n = (write_n || err_n) ? 32'd0 : mem_q[idx_n];

  assign mem_we = (state_q == S_RESP) && PSEL && PENABLE && write_q && !pslverr_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      write_q   <= 1'b0;
      prdata_q  <= 32'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'd0;
      case (state_q)
        S_IDLE: begin
          if (setup) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            cnt_q   <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state_q   <= S_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= err_n;
              prdata_q  <= rdata_n;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSEL) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
          end else if (PENABLE) begin
            if (cnt_q <= 4'd1) begin
              state_q   <= S_RESP;
              cnt_q     <= 4'd0;
              pready_q  <= 1'b1;
              pslverr_q <= err_n;
              prdata_q  <= rdata_n;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (mem_we) begin
      mem_q[addr_q[AW+1:2]] <= wdata_q;
    end
  end

  assign PRDATA      = prdata_q;
  assign PREADY      = pready_q;
  assign PSLVERR     = pslverr_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the number of 32-bit memory words (power of two, 16..1024).
REQ-002 Parameter WAIT_CYCLES, default 1, SHALL set the number of PREADY-low access cycles inserted per transfer (0..15).
REQ-003 PCLK  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 PRESET  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 PSEL  input  1  SHALL be the slave select from the APB master.
REQ-006 PENABLE  input  1  SHALL mark the access phase.
REQ-007 PWRITE  input  1  SHALL select write (1) or read (0).
REQ-008 PADDR  input  32  SHALL be the byte address.
REQ-009 PWDATA  input  32  SHALL be the write data.
REQ-010 PRDATA  output  32  SHALL be the read data, valid only while PREADY=1 on a read.
REQ-011 PREADY  output  1  SHALL be registered; high for exactly one cycle to complete a transfer.
REQ-012 PSLVERR  output  1  SHALL be registered; valid only while PREADY=1.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP.
REQ-014 IDLE: on an edge with PSEL=1, PENABLE=0, SHALL latch PADDR/PWRITE/PWDATA, load wait counter with WAIT_CYCLES, go to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-015 IDLE: PSEL=1 with PENABLE=1 (no setup phase) SHALL be ignored; stay IDLE, PREADY=0.
REQ-016 WAIT: counter SHALL decrement each edge with PSEL=PENABLE=1; at counter=1, go to RESP.
REQ-017 RESP: PREADY SHALL be 1 for one cycle; the next edge SHALL return to IDLE.
REQ-018 Latency: PREADY SHALL rise on access-phase cycle WAIT_CYCLES+1 (first access cycle when WAIT_CYCLES=0).
REQ-019 Word index SHALL be PADDR[log2(DEPTH)+1:2]; PADDR[1:0] are alignment bits.
REQ-020 Error SHALL be flagged when PADDR[1:0]!=0 or PADDR >= DEPTH*4; PSLVERR=1 in RESP.
REQ-021 Error write SHALL not modify memory; error read SHALL drive PRDATA=0.
REQ-022 Good write SHALL update the word at the RESP completing edge (PSEL=PENABLE=PREADY=1); PSLVERR=0.
REQ-023 Good read SHALL drive PRDATA with the stored word during RESP; PSLVERR=0.
REQ-024 PSEL deasserted in WAIT or RESP SHALL abort: return to IDLE, no memory write, PREADY=0 next cycle.
REQ-025 Outside RESP: PRDATA=0, PSLVERR=0, PREADY=0.
REQ-026 Back-to-back: a setup phase in the cycle after RESP SHALL be accepted with no dead cycle.
REQ-027 A read immediately after a write to the same address SHALL return the newly written data.

Reset
REQ-028 PRESET=1 at an edge SHALL force IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, all memory words=0.
REQ-029 PRESET mid-transfer SHALL discard the transfer with no memory write; PRESET overrides all other inputs.

Verification
REQ-030 WAIT_CYCLES=1: write 0xDEADBEEF @0x10, then read @0x10 -> PREADY on the 2nd access cycle each, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-031 Read @0x3FC (DEPTH=256) after write 0xA5A5A5A5 -> 0xA5A5A5A5; read @0x400 -> PSLVERR=1, PRDATA=0.
REQ-032 Write 0x12345678 @0x22 (misaligned) -> PSLVERR=1; read @0x20 -> 0x00000000.
REQ-033 WAIT_CYCLES=0: 4 back-to-back writes @0x0/0x4/0x8/0xC, then reads -> PREADY on the first access cycle, data matches, no idle gaps.
REQ-034 PSEL dropped in WAIT during write 0xCAFEF00D @0x40 -> no PREADY; read @0x40 -> 0x00000000.
REQ-035 PRESET asserted in WAIT after a prior write of 0x1 @0x8 -> outputs 0, IDLE next cycle, read @0x8 -> 0x00000000.
